// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC, sync-read instruction memory, PC-tagged queue to decode; redirect flushes.
// Issue-to-visible 2 cycles; inst_ready low fills the queue, after which issue stalls on occupancy.
module fetch_queue_unit #(
  parameter int                    INSTRUCTION_WIDTH = 16,
  parameter int                    ADDR_WIDTH        = 8,
  parameter int                    MEM_DEPTH         = 1 << ADDR_WIDTH,
  parameter int                    QUEUE_DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en_fetch,
  input  logic                             redirect_valid,
  input  logic [ADDR_WIDTH-1:0]            redirect_addr,
  input  logic                             load_en,
  input  logic [ADDR_WIDTH-1:0]            load_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]     load_data,
  output logic                             inst_valid,
  input  logic                             inst_ready,
  output logic [INSTRUCTION_WIDTH-1:0]     inst_data,
  output logic [ADDR_WIDTH-1:0]            inst_pc,
  output logic [ADDR_WIDTH-1:0]            fetch_pc,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTRUCTION_WIDTH-1:0] mem [MEM_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] rd_data;
  logic                         inflight;
  logic [ADDR_WIDTH-1:0]        inflight_pc;
  logic [ADDR_WIDTH-1:0]        pc;

  logic [INSTRUCTION_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]        q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;

  logic                         issue;
  logic                         push;
  logic                         pop;
  logic [CNT_W:0]               occupancy;

  // Reserving a slot for the in-flight read is what makes overflow impossible.
  assign occupancy  = {1'b0, count} + (CNT_W+1)'(inflight);
  assign issue      = en_fetch & ~redirect_valid & ~reset
                    & (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
  assign push       = inflight & ~redirect_valid;
  assign inst_valid = (count != '0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;

  assign inst_data   = q_data[head];
  assign inst_pc     = q_pc[head];
  assign fetch_pc    = pc;
  assign queue_count = count;

  // Read-before-write: a same-edge load at the issued address returns the old word.
  always_ff @(posedge clk) begin
    if (load_en && !reset) begin
      mem[load_addr] <= load_data;
    end
    if (issue) begin
      rd_data <= mem[pc];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end
      if (redirect_valid) begin
        pc <= redirect_addr;
      end else if (issue) begin
        pc <= pc + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_data[tail] <= rd_data;
        q_pc[tail]   <= inflight_pc;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: scoreboard of expected (pc, data) drained by output monitors.
module tb_fetch_queue_unit;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_fetch;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic        inst_ready;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [7:0]  inst_pc;
  logic [7:0]  fetch_pc;
  logic [2:0]  queue_count;

  logic        rdy2;
  logic        inst_valid2;
  logic [15:0] inst_data2;
  logic [7:0]  inst_pc2;
  logic [7:0]  fetch_pc2;
  logic [2:0]  queue_count2;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   seen     = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];
  exp_t m_e;
  exp_t m_e2;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .INSTRUCTION_WIDTH(16), .ADDR_WIDTH(8), .QUEUE_DEPTH(4), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .en_fetch(en_fetch),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .fetch_pc(fetch_pc), .queue_count(queue_count)
  );

  fetch_queue_unit #(
    .INSTRUCTION_WIDTH(16), .ADDR_WIDTH(8), .QUEUE_DEPTH(4), .RESET_PC(8'hFE)
  ) dut_wrap (
    .clk(clk), .reset(reset), .en_fetch(en_fetch),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(inst_valid2), .inst_ready(rdy2), .inst_data(inst_data2),
    .inst_pc(inst_pc2), .fetch_pc(fetch_pc2), .queue_count(queue_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors sample on the falling edge: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got pc 0x%0h data 0x%0h, expected nothing", inst_pc, inst_data);
      end else begin
        m_e = exp_q.pop_front();
        check("out_pc_data", {8'h0, inst_pc, inst_data}, {8'h0, m_e.pc, m_e.data});
      end
    end
  end

  always @(negedge clk) begin
    if (inst_valid2 === 1'b1 && rdy2 === 1'b1) begin
      if (exp2_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_wrap: got pc 0x%0h data 0x%0h, expected nothing", inst_pc2, inst_data2);
      end else begin
        m_e2 = exp2_q.pop_front();
        check("out_wrap_pc_data", {8'h0, inst_pc2, inst_data2}, {8'h0, m_e2.pc, m_e2.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [7:0] pc, input logic [15:0] d);
    exp_t e;
    e.pc   = pc;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_wrap(input logic [7:0] pc, input logic [15:0] d);
    exp_t e;
    e.pc   = pc;
    e.data = d;
    exp2_q.push_back(e);
  endtask

  // Hold inst_ready until n more handshakes are seen; drops ready before any extra one.
  task automatic consume(input int n, input int budget, output int took);
    int target;
    target     = seen + n;
    took       = 0;
    inst_ready = 1'b1;
    while (seen < target && took < budget) begin
      tick();
      took++;
    end
    inst_ready = 1'b0;
    if (seen < target) begin
      n_checks++;
      $display("FAIL consume_timeout: got %0d outputs, expected %0d", seen - (target - n), n);
    end
  endtask

  task automatic do_redirect(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int took;
    reset = 1'b1; en_fetch = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
    load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000; inst_ready = 1'b0; rdy2 = 1'b0;
    repeat (2) tick();

    check("rst_fetch_pc",    32'(fetch_pc),    32'h00);
    check("rst_queue_count", 32'(queue_count), 32'h0);
    check("rst_inst_valid",  32'(inst_valid),  32'h0);
    check("rst_inst_data",   32'(inst_data),   32'h0);
    check("rst_inst_pc",     32'(inst_pc),     32'h0);
    check("rst_wrap_pc",     32'(fetch_pc2),   32'hFE);

    // Program load with fetch idle: word at a = 0x1000 + a.
    reset = 1'b0;
    for (int a = 0; a < 256; a++) begin
      load_en = 1'b1; load_addr = 8'(a); load_data = 16'h1000 + 16'(a);
      tick();
    end
    load_en = 1'b0;
    check("idle_fetch_pc", 32'(fetch_pc), 32'h00);

    // Straight-line fetch: eight outputs by cycle 10, no gaps; wrap instance from 0xFE.
    reset = 1'b1;
    tick();
    reset = 1'b0; en_fetch = 1'b1;
    for (int i = 0; i < 8; i++) expect_out(8'(i), 16'h1000 + 16'(i));
    expect_wrap(8'hFE, 16'h10FE);
    expect_wrap(8'hFF, 16'h10FF);
    for (int i = 0; i < 6; i++) expect_wrap(8'(i), 16'h1000 + 16'(i));
    rdy2 = 1'b1;
    consume(8, 30, took);
    rdy2 = 1'b0;
    check("stream_cycles", 32'(took), 32'd10);

    // Decode stalled: queue saturates at 4, fetch_pc stops at 4, then drains in order.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("sat_queue_count", 32'(queue_count), 32'd4);
    check("sat_fetch_pc",    32'(fetch_pc),    32'h04);
    check("sat_head_pc",     32'(inst_pc),     32'h00);
    for (int i = 0; i < 8; i++) expect_out(8'(i), 16'h1000 + 16'(i));
    consume(8, 40, took);

    // Redirect with PCs 3..5 queued and PC 6 in flight.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) expect_out(8'(i), 16'h1000 + 16'(i));
    consume(3, 10, took);
    check("pre_redir_took", 32'(took), 32'd3);
    tick();
    check("pre_redir_count", 32'(queue_count), 32'd3);
    check("pre_redir_head",  32'(inst_pc),     32'h03);
    for (int i = 0; i < 4; i++) expect_out(8'h40 + 8'(i), 16'h1040 + 16'(i));
    redirect_valid = 1'b1; redirect_addr = 8'h40; inst_ready = 1'b1;
    #1;
    check("redir_cycle_valid", 32'(inst_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_r1_valid", 32'(inst_valid), 32'h0);
    tick();
    check("redir_r2_valid", 32'(inst_valid), 32'h0);
    tick();
    check("redir_r3_valid", 32'(inst_valid), 32'h1);
    check("redir_r3_pc",    32'(inst_pc),    32'h40);
    consume(4, 20, took);

    // Wrap-around through redirect to the top of the address space.
    expect_out(8'hFE, 16'h10FE);
    expect_out(8'hFF, 16'h10FF);
    expect_out(8'h00, 16'h1000);
    expect_out(8'h01, 16'h1001);
    do_redirect(8'hFE);
    consume(4, 20, took);

    // Load colliding with the issue of address 5 returns the old word; later reads see 0xBEEF.
    do_redirect(8'h05);
    load_en = 1'b1; load_addr = 8'h05; load_data = 16'hBEEF;
    tick();
    load_en = 1'b0;
    check("load_keeps_pc", 32'(fetch_pc), 32'h06);
    expect_out(8'h05, 16'h1005);
    expect_out(8'h06, 16'h1006);
    expect_out(8'h07, 16'h1007);
    consume(3, 20, took);
    expect_out(8'h05, 16'hBEEF);
    expect_out(8'h06, 16'h1006);
    do_redirect(8'h05);
    consume(2, 20, took);

    // Half-full queue, fetch disabled, then reset with a redirect and a load pending.
    do_redirect(8'h20);
    tick();
    tick();
    en_fetch = 1'b0;
    tick();
    check("half_queue_count", 32'(queue_count), 32'd2);
    check("half_fetch_pc",    32'(fetch_pc),    32'h22);
    reset = 1'b1; en_fetch = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 8'h77;
    load_en = 1'b1; load_addr = 8'h00; load_data = 16'hDEAD;
    tick();
    reset = 1'b0; redirect_valid = 1'b0; load_en = 1'b0;
    check("mid_rst_count",    32'(queue_count), 32'd0);
    check("mid_rst_valid",    32'(inst_valid),  32'h0);
    check("mid_rst_fetch_pc", 32'(fetch_pc),    32'h00);
    check("mid_rst_wrap_pc",  32'(fetch_pc2),   32'hFE);
    expect_out(8'h00, 16'h1000);
    expect_out(8'h01, 16'h1001);
    consume(2, 20, took);
    check("resume_cycles", 32'(took), 32'd4);

    check("scoreboard_empty",      32'(exp_q.size()),  32'd0);
    check("wrap_scoreboard_empty", 32'(exp2_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
